c2f_fifo: RTL and testbench
===========================

// Module: c2f_fifo
// PURPOSE
//  Buffers the CPU->FPGA burst-write beat stream produced by the TLP receiver (64-bit data plus
//  8-bit byte mask, valid only, no backpressure) and presents it to the FPGA-side consumer over a
//  valid/ready interface. Sits directly downstream of tlp_recv's c2f outputs, in the pcieClk_in
//  domain. Provides fill level, almost-full, a sticky overflow flag and an accepted-byte counter.
// PARAMETERS
//  DEPTH      16  entries of {BE,data}; power of two, >= 4
//  AF_MARGIN  4   almostFull_out asserts when level_out >= DEPTH-AF_MARGIN; 1..DEPTH-1
// PORTS
//  pcieClk_in      in   1             125MHz core clock; all logic on rising edge
//  pcieRstN_in     in   1             asynchronous, active-low reset
//  c2fData_in      in   64            beat data from tlp_recv
//  c2fBE_in        in   8             byte mask; bit i qualifies c2fData_in[8i+:8]
//  c2fValid_in     in   1             beat present this cycle; cannot be stalled
//  dsData_out      out  64            head-of-queue data
//  dsBE_out        out  8             head-of-queue byte mask
//  dsValid_out     out  1             head valid
//  dsReady_in      in   1             consumer takes head when dsValid_out && dsReady_in
//  level_out       out  $clog2(DEPTH)+1  entries held (RAM + output register)
//  almostFull_out  out  1             level_out >= DEPTH-AF_MARGIN
//  overflow_out    out  1             sticky: a beat was dropped for lack of space
//  byteCount_out   out  32            bytes accepted (popcount of BE), wraps mod 2^32
//  clearStats_in   in   1             synchronous clear of overflow_out and byteCount_out
// BEHAVIOUR
//  - Reset (async, pcieRstN_in=0): pointers, level_out, dsValid_out, dsData_out, dsBE_out,
//    almostFull_out, overflow_out, byteCount_out all 0; takes effect immediately, any in-flight
//    beat and queue contents discarded. Deassertion is sampled synchronously to pcieClk_in.
//  - Storage: DEPTH-1 entry circular RAM plus one output register (total capacity DEPTH).
//    Write/read pointers $clog2(DEPTH) bits with extra wrap bit; full/empty from pointer compare.
//  - Push: c2fValid_in && c2fBE_in!=0. Beats with c2fBE_in==0 are discarded silently (not stored,
//    not counted, no overflow).
//  - Pop: dsValid_out && dsReady_in. dsData_out/dsBE_out held stable while dsValid_out && !dsReady_in.
//  - Output stage FSM: S_EMPTY (dsValid_out=0) / S_VALID (dsValid_out=1).
//    S_EMPTY: push with RAM empty -> beat loaded directly into output reg, S_VALID next cycle
//      (latency 1: beat at edge N visible at N+1). Push with RAM non-empty cannot occur.
//    S_VALID: on pop, load RAM head if RAM non-empty (stay S_VALID), else load bypass push if
//      present (stay S_VALID), else -> S_EMPTY. Without pop, push goes to RAM.
//    Order is strictly FIFO; no beat overtakes an older one.
//  - level_out: +1 on accepted push, -1 on pop, unchanged when both; registered.
//  - Full (level_out==DEPTH): push without same-cycle pop is dropped, overflow_out<=1 next cycle;
//    push with same-cycle pop is accepted (level stays DEPTH).
//  - byteCount_out += popcount(c2fBE_in) per accepted push; dropped beats not counted.
//  - clearStats_in: overflow_out<=0 and byteCount_out<=0, except a same-cycle accepted push gives
//    byteCount_out=popcount(BE) and a same-cycle drop leaves overflow_out=1 (event wins).
//  - almostFull_out is combinational from registered level_out (no input paths).
//  - Pointer wrap at DEPTH-1 -> 0 toggles wrap bit; no behavioural seam across wrap.
// TESTING
//  1 Empty FIFO, push {BE=FF,D=0x1122334455667788}, dsReady_in=1 -> dsValid_out=1 next cycle with
//    that data, popped, level_out back to 0, byteCount_out=8.
//  2 dsReady_in=0, push 16 beats BE=FF then 1 more -> level_out=16, almostFull_out=1 from level 12,
//    17th dropped, overflow_out=1, byteCount_out=128; drain returns beats 0..15 in order.
//  3 Full FIFO, dsReady_in=1, push every cycle for 40 cycles -> no drops, overflow_out=0, output
//    sequence matches input across two pointer wraps.
//  4 Burst beats BE=F0, FF, FF, 0F, then BE=00 beat -> four beats delivered with masks intact,
//    BE=00 beat absent, byteCount_out=4+8+8+4=24.
//  5 clearStats_in with simultaneous push BE=0F after count 100 -> byteCount_out=4, overflow_out=0.
//  6 Assert pcieRstN_in=0 mid-burst with 5 entries queued -> all outputs 0 asynchronously; after
//    release, first new push emerges as first output with level_out=1.

Source files
------------

// File: rtl/c2f_fifo.sv
// ---------------------------------------------------------------------------
// c2f_fifo
//  Elastic buffer for the CPU->FPGA burst-write beat stream. The producer
//  (tlp_recv) cannot be stalled, so every beat with a non-zero byte mask is
//  either stored or dropped (dropping raises a sticky overflow flag). The
//  consumer side is a plain valid/ready interface driven from an output
//  register that is fed either from a small circular RAM or, when that RAM
//  is empty, directly from the incoming beat.
//
//  Storage = (DEPTH-1)-entry circular RAM + 1 output register = DEPTH beats.
//
//  Ports
//   pcieClk_in      core clock, all logic on the rising edge
//   pcieRstN_in     asynchronous active-low reset
//   c2fData_in      beat data (64 bit)
//   c2fBE_in        byte mask, bit i qualifies c2fData_in[8i+:8]
//   c2fValid_in     beat present this cycle (no backpressure)
//   dsData_out      head-of-queue data
//   dsBE_out        head-of-queue byte mask
//   dsValid_out     head valid
//   dsReady_in      consumer takes head when dsValid_out && dsReady_in
//   level_out       beats held (RAM + output register)
//   almostFull_out  level_out >= DEPTH-AF_MARGIN
//   overflow_out    sticky: a beat was dropped for lack of space
//   byteCount_out   bytes accepted (popcount of BE), wraps mod 2^32
//   clearStats_in   synchronous clear of overflow_out / byteCount_out
// ---------------------------------------------------------------------------
module c2f_fifo #(
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 4
) (
  input  logic                      pcieClk_in,
  input  logic                      pcieRstN_in,
  input  logic [63:0]               c2fData_in,
  input  logic [7:0]                c2fBE_in,
  input  logic                      c2fValid_in,
  output logic [63:0]               dsData_out,
  output logic [7:0]                dsBE_out,
  output logic                      dsValid_out,
  input  logic                      dsReady_in,
  output logic [$clog2(DEPTH):0]    level_out,
  output logic                      almostFull_out,
  output logic                      overflow_out,
  output logic [31:0]               byteCount_out,
  input  logic                      clearStats_in
);

  localparam int AW    = $clog2(DEPTH);   // RAM index width
  localparam int LW    = AW + 1;          // level / pointer width
  localparam int RAM_N = DEPTH - 1;       // RAM entries
  localparam int EW    = 72;              // {BE, data}

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_VALID = 1'b1
  } out_state_e;

  // Advance a {wrap, index} pointer; the index runs 0..RAM_N-1, so the wrap
  // bit toggles when stepping off the last RAM slot rather than at 2^AW.
  function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
    logic [AW:0] r;
    if (p[AW-1:0] == AW'(RAM_N - 1)) begin
      r = {~p[AW], {AW{1'b0}}};
    end else begin
      r = p + LW'(1);
    end
    return r;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  out_state_e        state_q;
  logic [63:0]       data_q;
  logic [7:0]        be_q;
  logic [AW:0]       wptr_q, wptr_d;
  logic [AW:0]       rptr_q, rptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       bcnt_q, bcnt_d;
  logic [EW-1:0]     mem_q [RAM_N];

  // -------------------------------------------------------------------------
  // Handshake / occupancy decode
  // -------------------------------------------------------------------------
  logic          push_req;
  logic          pop;
  logic          ram_empty;
  logic          ram_full;
  logic          fifo_full;
  logic          accept;
  logic          drop;
  logic [EW-1:0] ram_head;

  assign push_req  = c2fValid_in && (c2fBE_in != 8'h00);
  assign pop       = (state_q == S_VALID) && dsReady_in;
  assign ram_empty = (wptr_q == rptr_q);
  assign ram_full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  // Completely full only when the RAM is full and the output register holds a beat.
  assign fifo_full = ram_full && (state_q == S_VALID);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign accept    = push_req && (!fifo_full || pop);
  assign drop      = push_req && !accept;
  assign ram_head  = mem_q[rptr_q[AW-1:0]];

  // -------------------------------------------------------------------------
  // Output-stage steering
  // -------------------------------------------------------------------------
  logic ram_we;
  logic ram_re;
  logic out_load;
  logic out_from_ram;

  always_comb begin
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    out_load     = 1'b0;
    out_from_ram = 1'b0;
    unique case (state_q)
      S_EMPTY: begin
        // Output register empty implies RAM empty: bypass straight to output.
        out_load = accept;
      end
      S_VALID: begin
        if (pop) begin
          if (!ram_empty) begin
            // Older beats in RAM go first; a concurrent push queues behind them.
            ram_re       = 1'b1;
            out_load     = 1'b1;
            out_from_ram = 1'b1;
            ram_we       = accept;
          end else begin
            out_load = accept;
          end
        end else begin
          ram_we = accept;
        end
      end
      default: begin
        out_load = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output-stage FSM with registered head data
  // -------------------------------------------------------------------------
  always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
    if (!pcieRstN_in) begin
      state_q <= S_EMPTY;
      data_q  <= 64'd0;
      be_q    <= 8'd0;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (out_load) begin
            data_q  <= c2fData_in;
            be_q    <= c2fBE_in;
            state_q <= S_VALID;
          end
        end
        S_VALID: begin
          if (out_load) begin
            if (out_from_ram) begin
              data_q <= ram_head[63:0];
              be_q   <= ram_head[71:64];
            end else begin
              data_q <= c2fData_in;
              be_q   <= c2fBE_in;
            end
            state_q <= S_VALID;
          end else if (pop) begin
            state_q <= S_EMPTY;
          end
        end
        default: begin
          state_q <= S_EMPTY;
        end
      endcase
    end
  end

  // RAM array carries no reset; its contents are qualified by the pointers.
  always_ff @(posedge pcieClk_in) begin
    if (ram_we) begin
      mem_q[wptr_q[AW-1:0]] <= {c2fBE_in, c2fData_in};
    end
  end

  // -------------------------------------------------------------------------
  // Pointers, level and statistics
  // -------------------------------------------------------------------------
  always_comb begin
    wptr_d = ram_we ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = ram_re ? ptr_inc(rptr_q) : rptr_q;

    level_d = level_q;
    if (accept && !pop) begin
      level_d = level_q + LW'(1);
    end else if (!accept && pop) begin
      level_d = level_q - LW'(1);
    end

    // Same-cycle events win over a clear.
    if (clearStats_in) begin
      bcnt_d = accept ? {28'd0, popcount8(c2fBE_in)} : 32'd0;
      ovf_d  = drop;
    end else begin
      bcnt_d = accept ? bcnt_q + {28'd0, popcount8(c2fBE_in)} : bcnt_q;
      ovf_d  = ovf_q | drop;
    end
  end

  always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
    if (!pcieRstN_in) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
      bcnt_q  <= 32'd0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign dsValid_out    = (state_q == S_VALID);
  assign dsData_out     = data_q;
  assign dsBE_out       = be_q;
  assign level_out      = level_q;
  assign almostFull_out = (level_q >= LW'(DEPTH - AF_MARGIN));
  assign overflow_out   = ovf_q;
  assign byteCount_out  = bcnt_q;

endmodule

// File: tb/tb_c2f_fifo.sv
// Bench for c2f_fifo: directed scenarios plus a randomized phase. A queue
// model of the FIFO (count, contents, stats) runs on each clock edge; a
// separate monitor on the falling edge compares DUT status every cycle and
// pops/compares the expected beat on each valid/ready handshake.
module tb_c2f_fifo;

  localparam int DEPTH     = 16;
  localparam int AF_MARGIN = 4;
  localparam int LW        = $clog2(DEPTH) + 1;

  logic           clk;
  logic           rst_n;
  logic [63:0]    c2fData;
  logic [7:0]     c2fBE;
  logic           c2fValid;
  logic [63:0]    dsData;
  logic [7:0]     dsBE;
  logic           dsValid;
  logic           dsReady;
  logic [LW-1:0]  level;
  logic           almostFull;
  logic           overflow;
  logic [31:0]    byteCount;
  logic           clearStats;

  c2f_fifo #(.DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)) dut (
    .pcieClk_in     (clk),
    .pcieRstN_in    (rst_n),
    .c2fData_in     (c2fData),
    .c2fBE_in       (c2fBE),
    .c2fValid_in    (c2fValid),
    .dsData_out     (dsData),
    .dsBE_out       (dsBE),
    .dsValid_out    (dsValid),
    .dsReady_in     (dsReady),
    .level_out      (level),
    .almostFull_out (almostFull),
    .overflow_out   (overflow),
    .byteCount_out  (byteCount),
    .clearStats_in  (clearStats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [71:0] exp_q[$];
  int          m_cnt = 0;
  logic [31:0] m_bc  = 0;
  logic        m_ovf = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the FIFO as a bounded queue of DEPTH beats.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_cnt = 0;
        m_bc  = 0;
        m_ovf = 0;
        exp_q.delete();
      end else begin
        bit pop_m, push_m, acc, drp;
        logic [31:0] pc;
        pop_m  = (m_cnt > 0) && dsReady;
        push_m = c2fValid && (c2fBE != 8'h00);
        acc    = push_m && ((m_cnt < DEPTH) || pop_m);
        drp    = push_m && !acc;
        pc     = acc ? 32'($countones(c2fBE)) : 32'd0;
        m_cnt  = m_cnt + (acc ? 1 : 0) - (pop_m ? 1 : 0);
        if (acc) exp_q.push_back({c2fBE, c2fData});
        m_bc   = clearStats ? pc : m_bc + pc;
        m_ovf  = drp ? 1'b1 : (clearStats ? 1'b0 : m_ovf);
      end
    end
  end

  // Monitor: status every cycle, payload on each handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("dsValid", 64'(dsValid), 64'(m_cnt > 0));
        chk("level", 64'(level), 64'(m_cnt));
        chk("almostFull", 64'(almostFull), 64'(m_cnt >= DEPTH - AF_MARGIN));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("byteCount", 64'(byteCount), 64'(m_bc));
        if (dsValid && dsReady) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL pop_empty: DUT delivered %0h/%0h with nothing expected", dsBE, dsData);
          end else begin
            logic [71:0] e;
            e = exp_q.pop_front();
            chk("dsData", dsData, e[63:0]);
            chk("dsBE", 64'(dsBE), 64'(e[71:64]));
          end
        end
      end
    end
  end

  task automatic step(input logic v, input logic [7:0] be, input logic [63:0] d,
                      input logic rdy, input logic clr);
    c2fValid   = v;
    c2fBE      = be;
    c2fData    = d;
    dsReady    = rdy;
    clearStats = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 64'd0, rdy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    c2fValid = 0; c2fBE = 0; c2fData = 0; dsReady = 0; clearStats = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(dsValid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_bc", 64'(byteCount), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single beat round trip
    step(1'b1, 8'hFF, 64'h1122334455667788, 1'b1, 1'b0);
    chk("t1_valid", 64'(dsValid), 64'd1);
    chk("t1_data", dsData, 64'h1122334455667788);
    idle(1'b1, 1);
    chk("t1_level", 64'(level), 64'd0);
    chk("t1_bc", 64'(byteCount), 64'd8);

    // 2: fill, overflow, drain in order
    step(1'b0, 8'h00, 64'd0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'hFF, 64'(i), 1'b0, 1'b0);
      if (i == 11) chk("t2_af12", 64'(almostFull), 64'd1);
      if (i == 10) chk("t2_af11", 64'(almostFull), 64'd0);
    end
    chk("t2_level16", 64'(level), 64'd16);
    step(1'b1, 8'hFF, 64'hDEAD, 1'b0, 1'b0);
    chk("t2_ovf", 64'(overflow), 64'd1);
    chk("t2_bc", 64'(byteCount), 64'd128);
    chk("t2_level", 64'(level), 64'd16);
    idle(1'b1, 18);
    chk("t2_drained", 64'(level), 64'd0);

    // 3: full with simultaneous push/pop across pointer wraps
    step(1'b0, 8'h00, 64'd0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, 8'hFF, 64'h3000 + 64'(i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 8'hFF, 64'h3100 + 64'(i), 1'b1, 1'b0);
    chk("t3_ovf", 64'(overflow), 64'd0);
    chk("t3_level", 64'(level), 64'd16);
    chk("t3_bc", 64'(byteCount), 64'd448);
    idle(1'b1, 18);

    // 4: byte masks preserved, zero-mask beat discarded
    step(1'b0, 8'h00, 64'd0, 1'b0, 1'b1);
    step(1'b1, 8'hF0, 64'h4000, 1'b1, 1'b0);
    step(1'b1, 8'hFF, 64'h4001, 1'b1, 1'b0);
    step(1'b1, 8'hFF, 64'h4002, 1'b1, 1'b0);
    step(1'b1, 8'h0F, 64'h4003, 1'b1, 1'b0);
    step(1'b1, 8'h00, 64'h4004, 1'b1, 1'b0);
    chk("t4_bc", 64'(byteCount), 64'd24);
    idle(1'b1, 4);
    chk("t4_level", 64'(level), 64'd0);

    // 5: clear coinciding with a push
    step(1'b0, 8'h00, 64'd0, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b1, 8'hFF, 64'h5000 + 64'(i), 1'b1, 1'b0);
    step(1'b1, 8'h0F, 64'h500C, 1'b1, 1'b0);
    chk("t5_bc100", 64'(byteCount), 64'd100);
    step(1'b1, 8'h0F, 64'h500D, 1'b1, 1'b1);
    chk("t5_bc", 64'(byteCount), 64'd4);
    chk("t5_ovf", 64'(overflow), 64'd0);
    idle(1'b1, 4);

    // 6: asynchronous reset mid-burst
    for (int i = 0; i < 5; i++) step(1'b1, 8'hFF, 64'h6000 + 64'(i), 1'b0, 1'b0);
    c2fValid = 1'b0;
    c2fBE    = 8'h00;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 64'(dsValid), 64'd0);
    chk("t6_data", dsData, 64'd0);
    chk("t6_be", 64'(dsBE), 64'd0);
    chk("t6_level", 64'(level), 64'd0);
    chk("t6_af", 64'(almostFull), 64'd0);
    chk("t6_bc", 64'(byteCount), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 8'hFF, 64'h6ABC, 1'b0, 1'b0);
    chk("t6_level1", 64'(level), 64'd1);
    chk("t6_first", dsData, 64'h6ABC);
    idle(1'b1, 3);

    // Randomized traffic with varying consumer throughput
    for (int blk = 0; blk < 20; blk++) begin
      int rdy_pct;
      rdy_pct = $urandom_range(10, 95);
      for (int i = 0; i < 100; i++) begin
        logic        v, r, c;
        logic [7:0]  be;
        logic [63:0] d;
        v  = ($urandom % 4) != 0;
        be = (($urandom % 6) == 0) ? 8'h00 : 8'($urandom);
        d  = {$urandom, $urandom};
        r  = ($urandom % 100) < rdy_pct;
        c  = ($urandom % 60) == 0;
        step(v, be, d, r, c);
      end
    end
    idle(1'b1, 20);
    chk("final_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
